// File: rtl/crossbar_sync_if.sv
// crossbar_sync_if
//   Command/status bundle of the crossbar configuration port.
//   master : drives cmd_valid/cmd_op/cmd_from/cmd_to; observes cmd_ready, cmd_err, busy
//   slave  : the crossbar itself
//   A      : width of the cmd_from / cmd_to lane indices
interface crossbar_sync_if #(
  parameter int A = 8
) ();
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [A-1:0] cmd_from;
  logic [A-1:0] cmd_to;
  logic         cmd_err;
  logic         busy;

  modport master (
    output cmd_valid, cmd_op, cmd_from, cmd_to,
    input  cmd_ready, cmd_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_from, cmd_to,
    output cmd_ready, cmd_err, busy
  );
endinterface

// File: rtl/crossbar_sync.sv
// crossbar_sync
//   Synchronous IN x OUT crossbar of DW-bit lanes. Each output column holds
//   an IN-bit connection mask; an output lane is the registered OR of every
//   input lane enabled in its mask. Masks are edited through a valid/ready
//   command port (CONNECT, DISCONNECT, CLEAR_COL, CLEAR_ALL sweep).
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   in           : IN*DW input lanes, lane j = in[j*DW +: DW]
//   out          : OUT*DW registered output lanes
//   rd_to        : readback column select
//   rd_mask      : registered mask of column rd_to (zero when out of range)
//   cmd          : command/status interface (slave side)
module crossbar_sync #(
  parameter int DW  = 1,
  parameter int IN  = 8,
  parameter int OUT = 8,
  parameter int A   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IN*DW-1:0]  in,
  output logic [OUT*DW-1:0] out,
  input  logic [A-1:0]      rd_to,
  output logic [IN-1:0]     rd_mask,
  crossbar_sync_if.slave    cmd
);

  localparam logic [1:0] OP_CONNECT    = 2'd0;
  localparam logic [1:0] OP_DISCONNECT = 2'd1;
  localparam logic [1:0] OP_CLEAR_COL  = 2'd2;
  localparam logic [1:0] OP_CLEAR_ALL  = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [A-1:0]            cnt_q, cnt_d;
  logic [OUT-1:0][IN-1:0]  mask_q, mask_d;
  logic [OUT*DW-1:0]       out_q, out_d;
  logic [IN-1:0]           rd_mask_q, rd_mask_d;
  logic                    err_q, err_d;

  logic                    ready_s, busy_s, accept_s;
  logic                    to_bad_s, from_bad_s;
  logic [31:0]             to_ext_s, from_ext_s, rd_ext_s, cnt_ext_s;

  // Indices are widened to 32 bits so the range checks never wrap.
  assign to_ext_s   = 32'(cmd.cmd_to);
  assign from_ext_s = 32'(cmd.cmd_from);
  assign rd_ext_s   = 32'(rd_to);
  assign cnt_ext_s  = 32'(cnt_q);
  assign to_bad_s   = (to_ext_s >= 32'(OUT));
  assign from_bad_s = (from_ext_s >= 32'(IN));
  assign accept_s   = cmd.cmd_valid & ready_s;

  // State register: FSM, sweep counter, masks and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      out_q     <= '0;
      rd_mask_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      out_q     <= out_d;
      rd_mask_q <= rd_mask_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: command decode, mask edits and the CLEAR_ALL sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd.cmd_op)
            OP_CONNECT, OP_DISCONNECT: begin
              if (to_bad_s || from_bad_s) begin
                err_d = 1'b1;
              end else begin
                for (int i = 0; i < OUT; i++) begin
                  for (int j = 0; j < IN; j++) begin
                    mask_d[i][j] = ((to_ext_s == 32'(i)) && (from_ext_s == 32'(j)))
                                   ? (cmd.cmd_op == OP_CONNECT) : mask_d[i][j];
                  end
                end
              end
            end
            OP_CLEAR_COL: begin
              if (to_bad_s) begin
                err_d = 1'b1;
              end else begin
                for (int i = 0; i < OUT; i++) begin
                  mask_d[i] = (to_ext_s == 32'(i)) ? '0 : mask_d[i];
                end
              end
            end
            OP_CLEAR_ALL: begin
              state_d = ST_SWEEP;
              cnt_d   = '0;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        for (int i = 0; i < OUT; i++) begin
          mask_d[i] = (cnt_ext_s == 32'(i)) ? '0 : mask_d[i];
        end
        // The edge that clears the last column also ends the sweep.
        if (cnt_ext_s == 32'(OUT - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + A'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode of the FSM state.
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      ST_SWEEP: begin
        ready_s = 1'b0;
        busy_s  = 1'b1;
      end
      default: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Datapath: OR of connected input lanes per column, and column readback.
  always_comb begin
    out_d     = '0;
    rd_mask_d = '0;
    for (int i = 0; i < OUT; i++) begin
      for (int j = 0; j < IN; j++) begin
        out_d[i*DW +: DW] = out_d[i*DW +: DW] | (in[j*DW +: DW] & {DW{mask_q[i][j]}});
      end
      rd_mask_d = rd_mask_d | (mask_q[i] & {IN{rd_ext_s == 32'(i)}});
    end
  end

  assign out           = out_q;
  assign rd_mask       = rd_mask_q;
  assign cmd.cmd_err   = err_q;
  assign cmd.cmd_ready = ready_s;
  assign cmd.busy      = busy_s;

endmodule

// File: tb/tb_crossbar_sync.sv
// tb_crossbar_sync
//   Directed scenarios plus randomized traffic for crossbar_sync
//   (DW=4, IN=OUT=8, A=8), checked cycle by cycle against an array-based
//   reference model of the routing table.
module tb_crossbar_sync;
  localparam int DW  = 4;
  localparam int IN  = 8;
  localparam int OUT = 8;
  localparam int A   = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [IN*DW-1:0]  in_s;
  logic [OUT*DW-1:0] out_s;
  logic [A-1:0]      rd_to_s;
  logic [IN-1:0]     rd_mask_s;

  crossbar_sync_if #(.A(A)) cmd_if ();

  crossbar_sync #(.DW(DW), .IN(IN), .OUT(OUT), .A(A)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in_s),
    .out     (out_s),
    .rd_to   (rd_to_s),
    .rd_mask (rd_mask_s),
    .cmd     (cmd_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: connection table and remaining sweep length.
  bit [IN-1:0]       mdl_mask [OUT];
  int                sweep_left;
  logic [OUT*DW-1:0] exp_out;
  logic [IN-1:0]     exp_rd;
  logic              exp_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < OUT; i++) mdl_mask[i] = '0;
    sweep_left = 0;
  endtask

  // One clock: predict outputs from the pre-edge table, apply the edge, then compare.
  task automatic cycle();
    int f, t;
    @(posedge clk);
    exp_out = '0;
    for (int i = 0; i < OUT; i++)
      for (int j = 0; j < IN; j++)
        if (mdl_mask[i][j]) exp_out[i*DW +: DW] = exp_out[i*DW +: DW] | in_s[j*DW +: DW];
    exp_rd  = (int'(rd_to_s) < OUT) ? mdl_mask[int'(rd_to_s)] : '0;
    exp_err = 1'b0;
    f = int'(cmd_if.cmd_from);
    t = int'(cmd_if.cmd_to);
    if (sweep_left > 0) begin
      mdl_mask[OUT - sweep_left] = '0;
      sweep_left--;
    end else if (cmd_if.cmd_valid) begin
      case (cmd_if.cmd_op)
        2'd0, 2'd1: begin
          if (t >= OUT || f >= IN) exp_err = 1'b1;
          else mdl_mask[t][f] = (cmd_if.cmd_op == 2'd0);
        end
        2'd2: begin
          if (t >= OUT) exp_err = 1'b1;
          else mdl_mask[t] = '0;
        end
        default: sweep_left = OUT;
      endcase
    end
    @(negedge clk);
    check_eq("out", out_s, exp_out);
    check_eq("rd_mask", rd_mask_s, exp_rd);
    check_eq("cmd_err", cmd_if.cmd_err, exp_err);
    check_eq("cmd_ready", cmd_if.cmd_ready, sweep_left == 0);
    check_eq("busy", cmd_if.busy, sweep_left != 0);
  endtask

  task automatic issue(input logic [1:0] op, input int from, input int to);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_from  = A'(from);
    cmd_if.cmd_to    = A'(to);
    cycle();
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int r;
    reset_n          = 1'b0;
    in_s             = '1;
    rd_to_s          = '0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_from  = '0;
    cmd_if.cmd_to    = '0;
    model_clear();

    // 1: reset state with all-ones inputs
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rst_out", out_s, '0);
    check_eq("rst_rd_mask", rd_mask_s, '0);
    check_eq("rst_ready", cmd_if.cmd_ready, 1'b1);
    check_eq("rst_busy", cmd_if.busy, 1'b0);
    @(negedge clk);
    cycle();

    // 2: single crosspoint, lane 3 -> column 5
    in_s = '0;
    in_s[3*DW +: DW] = 4'hA;
    rd_to_s = 8'd5;
    issue(2'd0, 3, 5);
    cycle();
    check_eq("t2_lane5", out_s[5*DW +: DW], 4'hA);
    check_eq("t2_rd_mask", rd_mask_s, 8'h08);
    check_eq("t2_others", out_s & ~(32'hF << (5*DW)), '0);

    // 3: fan-in onto column 0, then remove one source
    in_s = '0;
    in_s[1*DW +: DW] = 4'h3;
    in_s[2*DW +: DW] = 4'hC;
    rd_to_s = 8'd0;
    issue(2'd0, 1, 0);
    issue(2'd0, 2, 0);
    cycle();
    check_eq("t3_fanin", out_s[0 +: DW], 4'hF);
    issue(2'd1, 2, 0);
    cycle();
    check_eq("t3_disc", out_s[0 +: DW], 4'h3);
    issue(2'd0, 1, 0);  // idempotent reconnect
    check_eq("t3_idem_err", cmd_if.cmd_err, 1'b0);

    // 4: range errors
    rd_to_s = 8'd2;
    issue(2'd0, 9, 2);
    check_eq("t4_err_from", cmd_if.cmd_err, 1'b1);
    cycle();
    check_eq("t4_err_drop", cmd_if.cmd_err, 1'b0);
    check_eq("t4_col2", rd_mask_s, 8'h00);
    issue(2'd2, 0, 8);
    check_eq("t4_err_col", cmd_if.cmd_err, 1'b1);
    issue(2'd1, 0, 200);
    check_eq("t4_err_wide", cmd_if.cmd_err, 1'b1);

    // 5: fill all crosspoints, CLEAR_ALL with a queued CONNECT(0,0)
    in_s = $urandom;
    for (int t = 0; t < OUT; t++)
      for (int f = 0; f < IN; f++) issue(2'd0, f, t);
    issue(2'd3, 5, 5);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_from  = '0;
    cmd_if.cmd_to    = '0;
    busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (!cmd_if.busy) break;
      busy_cnt++;
      cycle();
    end
    check_eq("t5_busy_len", busy_cnt, 8);
    cycle();
    cmd_if.cmd_valid = 1'b0;
    for (int t = 0; t < OUT; t++) begin
      rd_to_s = A'(t);
      cycle();
    end
    rd_to_s = 8'd0;
    cycle();
    check_eq("t5_col0", rd_mask_s, 8'h01);

    // 6: reset in the middle of a sweep
    for (int t = 0; t < OUT; t++) issue(2'd0, t, t);
    issue(2'd3, 0, 0);
    repeat (2) cycle();
    reset_n = 1'b0;
    #1;
    model_clear();
    check_eq("t6_busy", cmd_if.busy, 1'b0);
    check_eq("t6_ready", cmd_if.cmd_ready, 1'b1);
    check_eq("t6_out", out_s, '0);
    @(negedge clk);
    reset_n = 1'b1;
    in_s = '1;
    for (int t = 0; t < OUT; t++) begin
      rd_to_s = A'(t);
      cycle();
    end
    rd_to_s = 8'd4;
    issue(2'd0, 6, 4);
    cycle();
    check_eq("t6_connect", rd_mask_s, 8'h40);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 15);
      cmd_if.cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_if.cmd_op    = (r < 7) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      cmd_if.cmd_from  = ($urandom_range(0, 19) == 0) ? A'($urandom_range(200, 255)) : A'($urandom_range(0, 9));
      cmd_if.cmd_to    = ($urandom_range(0, 19) == 0) ? A'($urandom_range(200, 255)) : A'($urandom_range(0, 9));
      rd_to_s          = A'($urandom_range(0, 9));
      in_s             = $urandom;
      cycle();
    end
    cmd_if.cmd_valid = 1'b0;
    repeat (OUT + 1) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
